// File: rtl/vgalcd_fb_fetch.sv
// Framebuffer fetch controller: bursts one frame from memory into a
// 64-bit FWFT prefetch FIFO and presents it as a valid/ready pixel stream.
module vgalcd_fb_fetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 32,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic [ADDR_WIDTH-1:0] fb_base_i,
    input  logic [23:0]           fb_words_i,
    input  logic                  vend_i,
    input  logic                  clr_i,
    output logic                  rd_req_valid_o,
    input  logic                  rd_req_ready_i,
    output logic [ADDR_WIDTH-1:0] rd_req_addr_o,
    output logic [7:0]            rd_req_len_o,
    input  logic                  rd_rsp_valid_i,
    input  logic [63:0]           rd_rsp_data_i,
    input  logic                  rd_rsp_last_i,
    output logic                  pixel_valid_o,
    input  logic                  pixel_ready_i,
    output logic [63:0]           pixel_data_o,
    output logic                  underrun_o,
    output logic                  busy_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [23:0]           rem_q, rem_d;
    logic                  restart_q, restart_d;
    logic                  drop_q, drop_d;
    logic                  flush;

    logic [63:0]           mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         free;
    logic [23:0]           beats;
    logic                  handshake;
    logic                  beat;
    logic                  discard;
    logic                  push;
    logic                  pop;
    logic                  under_set;

    assign free      = CW'(FIFO_DEPTH) - count;
    assign beats     = (rem_q < 24'(BURST_LEN)) ? rem_q : 24'(BURST_LEN);

    assign rd_req_valid_o = (state_q == S_REQ) && (rem_q != '0)
                         && (free >= CW'(BURST_LEN));
    assign rd_req_addr_o  = addr_q;
    assign rd_req_len_o   = (rem_q != '0) ? 8'(beats - 24'd1) : 8'd0;

    assign handshake = rd_req_valid_o && rd_req_ready_i;
    assign beat      = (state_q == S_DATA) && rd_rsp_valid_i;
    // Beats of an aborted or disabled burst are dropped; the FIFO is
    // flushed when the burst's last beat arrives anyway.
    assign discard   = restart_q || drop_q || vend_i || !en_i;
    assign push      = beat && !discard;

    assign pixel_valid_o = (count != '0) && en_i;
    assign pop           = pixel_valid_o && pixel_ready_i;
    assign pixel_data_o  = pixel_valid_o ? mem[rd_ptr] : '0;
    assign busy_o        = (state_q != S_IDLE);

    assign under_set = en_i && pixel_ready_i && !pixel_valid_o
                    && (state_q != S_IDLE);

    // State, address, remaining-words and pending-abort registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            restart_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            restart_q <= restart_d;
            drop_q    <= drop_d;
        end
    end

    // Next-state logic: frame sequencing, aborts on vend_i, disable.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        restart_d = restart_q;
        drop_d    = drop_q;
        flush     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_i && vend_i) begin
                    addr_d  = fb_base_i;
                    rem_d   = fb_words_i;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (handshake) begin
                    // An accepted request must be drained even if the
                    // frame is aborted or fetching disabled this cycle.
                    addr_d    = addr_q + ADDR_WIDTH'({beats, 3'b000});
                    rem_d     = rem_q - beats;
                    restart_d = vend_i;
                    drop_d    = !en_i;
                    state_d   = S_DATA;
                end else if (!en_i) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else if (vend_i) begin
                    flush  = 1'b1;
                    addr_d = fb_base_i;
                    rem_d  = fb_words_i;
                end else if (rem_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DATA: begin
                if (!en_i) begin
                    drop_d = 1'b1;
                end
                if (vend_i) begin
                    restart_d = 1'b1;
                end
                if (beat && rd_rsp_last_i) begin
                    restart_d = 1'b0;
                    drop_d    = 1'b0;
                    if (drop_q || !en_i) begin
                        flush   = 1'b1;
                        state_d = S_IDLE;
                    end else if (restart_q || vend_i) begin
                        flush   = 1'b1;
                        addr_d  = fb_base_i;
                        rem_d   = fb_words_i;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                if (!en_i) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else if (vend_i) begin
                    addr_d  = fb_base_i;
                    rem_d   = fb_words_i;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointers and occupancy; flush overrides push and pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= rd_rsp_data_i;
        end
    end

    // Sticky underrun flag; a new underrun wins over a clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            underrun_o <= 1'b0;
        end else if (under_set) begin
            underrun_o <= 1'b1;
        end else if (clr_i) begin
            underrun_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vgalcd_fb_fetch.sv
// Directed bench for vgalcd_fb_fetch with a burst memory responder
// and a pixel sink that records every popped word.
module tb_vgalcd_fb_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] fb_base;
    logic [23:0] fb_words;
    logic        vend;
    logic        clr;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [31:0] rd_req_addr;
    logic [7:0]  rd_req_len;
    logic        rd_rsp_valid;
    logic [63:0] rd_rsp_data;
    logic        rd_rsp_last;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [63:0] pixel_data;
    logic        underrun;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rsp_delay;
    int          beat_idx;
    logic [31:0] req_addr_q[$];
    logic [7:0]  req_len_q[$];
    logic [63:0] pix_q[$];
    logic [31:0] r_addr;
    logic [7:0]  r_len;

    vgalcd_fb_fetch dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .en_i           (en),
        .fb_base_i      (fb_base),
        .fb_words_i     (fb_words),
        .vend_i         (vend),
        .clr_i          (clr),
        .rd_req_valid_o (rd_req_valid),
        .rd_req_ready_i (rd_req_ready),
        .rd_req_addr_o  (rd_req_addr),
        .rd_req_len_o   (rd_req_len),
        .rd_rsp_valid_i (rd_rsp_valid),
        .rd_rsp_data_i  (rd_rsp_data),
        .rd_rsp_last_i  (rd_rsp_last),
        .pixel_valid_o  (pixel_valid),
        .pixel_ready_i  (pixel_ready),
        .pixel_data_o   (pixel_data),
        .underrun_o     (underrun),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] word_at(logic [31:0] a);
        return {~a, a};
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: logs each accepted request and returns its beats.
    initial begin
        rd_rsp_valid = 1'b0;
        rd_rsp_data  = '0;
        rd_rsp_last  = 1'b0;
        beat_idx     = -1;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rd_req_valid && rd_req_ready) begin
                r_addr = rd_req_addr;
                r_len  = rd_req_len;
                req_addr_q.push_back(r_addr);
                req_len_q.push_back(r_len);
                @(posedge clk); #1;
                repeat (rsp_delay) begin
                    @(posedge clk); #1;
                end
                for (int i = 0; i <= int'(r_len); i++) begin
                    beat_idx     = i;
                    rd_rsp_valid = 1'b1;
                    rd_rsp_data  = word_at(r_addr + 32'(8 * i));
                    rd_rsp_last  = (i == int'(r_len));
                    @(posedge clk); #1;
                end
                rd_rsp_valid = 1'b0;
                rd_rsp_last  = 1'b0;
                beat_idx     = -1;
            end
        end
    end

    // Pixel sink: records the head word whenever a pop will occur.
    initial begin
        forever begin
            @(negedge clk);
            if (pixel_valid && pixel_ready) begin
                pix_q.push_back(pixel_data);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        en           = 1'b0;
        vend         = 1'b0;
        clr          = 1'b0;
        pixel_ready  = 1'b0;
        rd_req_ready = 1'b0;
        tick(70);
        rst_n     = 1'b0;
        rsp_delay = 0;
        fb_base   = '0;
        fb_words  = '0;
        tick(3);
        rst_n = 1'b1;
        req_addr_q.delete();
        req_len_q.delete();
        pix_q.delete();
        rd_req_ready = 1'b1;
        tick(1);
    endtask

    task automatic pulse_vend();
        vend = 1'b1;
        tick(1);
        vend = 1'b0;
    endtask

    task automatic wait_req(string tag, int n, int bound);
        for (int k = 0; k < bound && req_addr_q.size() < n; k++) begin
            tick(1);
        end
        check(tag, 64'(req_addr_q.size() >= n), 64'd1);
    endtask

    task automatic wait_valid(string tag, int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (rd_req_valid) break;
        end
        check(tag, 64'(rd_req_valid), 64'd1);
    endtask

    task automatic drain(string tag, int n, int bound);
        for (int k = 0; k < bound; k++) begin
            @(posedge clk); #1;
            if (pix_q.size() >= n) break;
            pixel_ready = pixel_valid;
        end
        pixel_ready = 1'b0;
        check(tag, 64'(pix_q.size()), 64'(n));
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();

        // Reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_valid", 64'(rd_req_valid), 64'd0);
        check("rst_req_addr", 64'(rd_req_addr), 64'd0);
        check("rst_req_len", 64'(rd_req_len), 64'd0);
        check("rst_pix_valid", 64'(pixel_valid), 64'd0);
        check("rst_pix_data", pixel_data, 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);

        // Basic frame of 20 words
        fb_base  = 32'h1000;
        fb_words = 24'd20;
        en       = 1'b1;
        pulse_vend();
        tick(80);
        check("t1_nreq", 64'(req_addr_q.size()), 64'd3);
        check("t1_req0_addr", 64'(req_addr_q[0]), 64'h1000);
        check("t1_req0_len", 64'(req_len_q[0]), 64'd7);
        check("t1_req1_addr", 64'(req_addr_q[1]), 64'h1040);
        check("t1_req1_len", 64'(req_len_q[1]), 64'd7);
        check("t1_req2_addr", 64'(req_addr_q[2]), 64'h1080);
        check("t1_req2_len", 64'(req_len_q[2]), 64'd3);
        check("t1_done_busy", 64'(busy), 64'd1);
        check("t1_done_req", 64'(rd_req_valid), 64'd0);
        drain("t1_drain", 20, 60);
        for (int k = 0; k < 20; k++) begin
            check("t1_pix", pix_q[k], word_at(32'h1000 + 32'(8 * k)));
        end
        tick(3);
        check("t1_underrun", 64'(underrun), 64'd0);
        check("t1_empty", 64'(pixel_valid), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);

        // Zero-size frame fetches nothing
        do_reset();
        fb_base  = 32'h7000;
        fb_words = 24'd0;
        en       = 1'b1;
        pulse_vend();
        tick(5);
        check("t0_nreq", 64'(req_addr_q.size()), 64'd0);
        check("t0_req_valid", 64'(rd_req_valid), 64'd0);
        check("t0_busy", 64'(busy), 64'd1);

        // Reservation with a stalled sink
        do_reset();
        fb_base  = 32'h4000;
        fb_words = 24'd100;
        en       = 1'b1;
        pulse_vend();
        tick(150);
        check("t2_nreq4", 64'(req_addr_q.size()), 64'd4);
        check("t2_stall", 64'(rd_req_valid), 64'd0);
        drain("t2_drain", 8, 40);
        check("t2_pix0", pix_q[0], word_at(32'h4000));
        check("t2_pix7", pix_q[7], word_at(32'h4038));
        tick(40);
        check("t2_nreq5", 64'(req_addr_q.size()), 64'd5);
        check("t2_req4_addr", 64'(req_addr_q[4]), 64'h4100);
        check("t2_req4_len", 64'(req_len_q[4]), 64'd7);
        check("t2_stall2", 64'(rd_req_valid), 64'd0);

        // Request backpressure
        do_reset();
        rd_req_ready = 1'b0;
        fb_base      = 32'h5000;
        fb_words     = 24'd100;
        en           = 1'b1;
        pulse_vend();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 64'(rd_req_valid), 64'd1);
            check("t3_hold_addr", 64'(rd_req_addr), 64'h5000);
            check("t3_hold_len", 64'(rd_req_len), 64'd7);
            @(posedge clk); #1;
        end
        rd_req_ready = 1'b1;
        tick(1);
        rd_req_ready = 1'b0;
        check("t3_rem", 64'(dut.rem_q), 64'd92);
        tick(20);
        check("t3_nreq", 64'(req_addr_q.size()), 64'd1);
        check("t3_rem_once", 64'(dut.rem_q), 64'd92);
        check("t3_next_addr", 64'(rd_req_addr), 64'h5040);

        // Early vend_i during burst 2
        do_reset();
        rsp_delay = 3;
        fb_base   = 32'h2000;
        fb_words  = 24'd40;
        en        = 1'b1;
        pulse_vend();
        wait_req("t4_wait_req2", 2, 60);
        pulse_vend();
        wait_valid("t4_wait_restart", 40);
        check("t4_restart_addr", 64'(rd_req_addr), 64'h2000);
        check("t4_restart_len", 64'(rd_req_len), 64'd7);
        check("t4_flushed", 64'(pixel_valid), 64'd0);
        drain("t4_drain", 8, 40);
        check("t4_pix0", pix_q[0], word_at(32'h2000));
        check("t4_pix7", pix_q[7], word_at(32'h2038));
        en = 1'b0;

        // Underrun with a slow memory
        do_reset();
        rsp_delay   = 50;
        fb_base     = 32'h6000;
        fb_words    = 24'd16;
        en          = 1'b1;
        pixel_ready = 1'b1;
        tick(2);
        check("t5_idle_no_ur", 64'(underrun), 64'd0);
        pulse_vend();
        tick(3);
        check("t5_ur_set", 64'(underrun), 64'd1);
        tick(10);
        check("t5_ur_sticky", 64'(underrun), 64'd1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("t5_ur_set_wins", 64'(underrun), 64'd1);
        pixel_ready = 1'b0;
        clr         = 1'b1;
        tick(1);
        clr = 1'b0;
        check("t5_ur_clr", 64'(underrun), 64'd0);
        tick(2);
        check("t5_ur_stays_clr", 64'(underrun), 64'd0);
        pixel_ready = 1'b1;
        clr         = 1'b1;
        tick(1);
        clr = 1'b0;
        check("t5_ur_again", 64'(underrun), 64'd1);
        pixel_ready = 1'b0;
        en          = 1'b0;
        tick(80);
        check("t5_idle", 64'(busy), 64'd0);

        // Disable on beat 3 of 8, then restart
        do_reset();
        fb_base  = 32'h3000;
        fb_words = 24'd8;
        en       = 1'b1;
        pulse_vend();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rd_rsp_valid && beat_idx == 2) break;
        end
        check("t6_at_beat3", 64'(beat_idx), 64'd2);
        check("t6_valid_before", 64'(pixel_valid), 64'd1);
        en = 1'b0;
        #1;
        check("t6_valid_drop", 64'(pixel_valid), 64'd0);
        check("t6_busy_mid", 64'(busy), 64'd1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("t6_idle", 64'(busy), 64'd0);
        check("t6_count", 64'(dut.count), 64'd0);
        check("t6_beats_done", 64'(beat_idx == -1), 64'd1);
        @(posedge clk); #1;
        en = 1'b1;
        pulse_vend();
        wait_valid("t6_wait_restart", 10);
        check("t6_restart_addr", 64'(rd_req_addr), 64'h3000);
        check("t6_restart_len", 64'(rd_req_len), 64'd7);
        drain("t6_drain", 8, 40);
        check("t6_pix0", pix_q[0], word_at(32'h3000));
        check("t6_pix7", pix_q[7], word_at(32'h3038));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vgalcd_fb_fetch.md
Name: vgalcd_fb_fetch

Overview:
Framebuffer fetch controller that sequences the VGA/LCD pixel datapath. It issues burst reads for one frame from a linear framebuffer in memory. Returned 64-bit words are buffered in an internal FIFO and presented to the core as a valid/ready pixel stream. It restarts at each frame end and flags underruns.

Parameters:
ADDR_WIDTH, 32, byte address width of the memory read port.
FIFO_DEPTH, 32, 64-bit word entries in the prefetch FIFO; power of two, >= 2*BURST_LEN.
BURST_LEN, 8, maximum beats per read burst; power of two, 1..256.

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
en_i  in  1  fetch enable
fb_base_i  in  ADDR_WIDTH  framebuffer base byte address; must be 8-byte aligned
fb_words_i  in  24  frame size in 64-bit words; 0 means fetch nothing
vend_i  in  1  end-of-frame pulse from the timing generator
clr_i  in  1  clears underrun_o
rd_req_valid_o  out  1  read request valid
rd_req_ready_i  in  1  read request accepted
rd_req_addr_o  out  ADDR_WIDTH  burst start byte address
rd_req_len_o  out  8  burst beats minus one
rd_rsp_valid_i  in  1  read data beat valid; no backpressure is allowed
rd_rsp_data_i  in  64  read data beat
rd_rsp_last_i  in  1  last beat of the burst
pixel_valid_o  out  1  FIFO head valid
pixel_ready_i  in  1  core consumes the head word
pixel_data_o  out  64  FIFO head word, 4 RGB pixels (LSB pixel first)
underrun_o  out  1  sticky underrun flag
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, FIFO empty, address = 0, remaining = 0, all outputs 0.
- States:
  - IDLE
    - On en_i && vend_i: load addr = fb_base_i and rem = fb_words_i, then go to REQ.
    - The first frame always starts on a vend_i pulse.
  - REQ
    - If rem == 0, go to DONE.
    - Else if free >= BURST_LEN, assert rd_req_valid_o with addr and len = min(BURST_LEN, rem) - 1.
    - free = FIFO_DEPTH - count.
    - Address and length are held stable while valid is high and ready is low.
    - On handshake: addr += 8*beats, rem -= beats, go to DATA.
  - DATA
    - Push every rd_rsp_valid_i beat into the FIFO.
    - Space is guaranteed by the reservation made in REQ; overflow is impossible by construction.
    - On a beat with rd_rsp_last_i, go to REQ.
    - rd_rsp_valid_i outside DATA is ignored.
  - DONE
    - On vend_i: reload addr and rem from the inputs, then go to REQ.
    - The FIFO is not flushed; it drains naturally.
- Frame abort: vend_i arriving in REQ or DATA means the frame was not fully fetched.
  - REQ (no request outstanding): flush the FIFO, reload, and stay in REQ in the same cycle.
  - DATA: set restart_pend. The burst completes, but its beats are discarded. On the last beat, flush, reload, go to REQ, and clear restart_pend.
  - A handshake and vend_i in the same REQ cycle count as DATA entry, so restart_pend is set.
- Disable: en_i low in IDLE, REQ or DONE means flush and go to IDLE immediately.
  - If en_i falls in DATA, remaining beats are discarded until the last beat, then flush and go to IDLE.
  - rd_req_valid_o drops only when no handshake occurred. A request already raised may complete and then drain as above.
- FIFO:
  - First-word-fall-through; pixel_valid_o = !empty && en_i.
  - A pop happens on pixel_valid_o && pixel_ready_i.
  - A push and a pop in the same cycle leave count unchanged.
  - A flush overrides both push and pop.
  - Zero-cycle latency from write to valid is not required: a pushed word becomes visible at the head the next cycle.
- Underrun:
  - underrun_o sets when en_i && pixel_ready_i && !pixel_valid_o && state != IDLE.
  - It stays sticky until clr_i; if set and clr_i occur in the same cycle, set wins.
- rem and addr are unsigned.
  - Address wrap past 2^ADDR_WIDTH is not checked; software guarantees the range.
  - fb_words_i changes take effect only at reload.

Test Plan:
- Basic frame: base=0x1000, words=20, BURST_LEN=8, memory ready immediately, pixels consumed after the FIFO fills.
  - Requests are (0x1000, len 7), (0x1040, len 7), (0x1080, len 3).
  - The FIFO delivers the 20 words in order, then the block sits in DONE with underrun_o=0.
- Reservation: pixel_ready_i held low, FIFO_DEPTH=32.
  - Exactly 4 bursts are issued, then rd_req_valid_o stays low.
  - Popping 8 words allows exactly one more request.
- Request backpressure: rd_req_ready_i low for 5 cycles.
  - addr and len are stable throughout, one handshake occurs, and rem decrements once.
- Early vend_i during DATA of burst 2 (words=40).
  - The remainder of burst 2 is discarded, the FIFO is flushed after the last beat, and the next request is (base, len 7).
- Underrun: memory rsp delayed 50 cycles while pixel_ready_i=1.
  - underrun_o rises and stays high; clr_i pulse clears it; simultaneous underrun and clr_i leaves it 1.
- Disable mid-burst: en_i falls on beat 3 of 8.
  - pixel_valid_o=0 immediately, the remaining beats are consumed, IDLE is entered after last, and busy_o=0, count=0.
  - Re-enable plus vend_i restarts from base.
